irq_req_conditioner: RTL

Request front end placed directly upstream of the 4-line interrupt controller `inc`. It synchronises asynchronous raw interrupt lines and applies per-line edge or level triggering and masking. Edge events are latched as pending until the controller acknowledges them. The resulting `req` vector drives `inc.inp`, and `inc.out` (the one-hot ack) feeds back as `ack`.

---
 rtl/inc_pkg.sv | 15 +
 rtl/irq_sync.sv | 38 +++
 rtl/irq_req_conditioner.sv | 110 +++++++++++
 3 files changed

// File: rtl/inc_pkg.sv
// Shared constants for the interrupt controller (inc) and its request
// front end (irq_req_conditioner).
//
// Contents:
//   N_IRQ_DEF   - default number of interrupt lines (inc is built for 4)
//   TRIG_LEVEL  - trigger encoding for a level-sensitive line
//   TRIG_EDGE   - trigger encoding for a rising-edge latched line
package inc_pkg;

    localparam int   N_IRQ_DEF  = 4;

    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EDGE  = 1'b1;

endpackage

// File: rtl/irq_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous inputs.
// Each bit is synchronised independently; no cross-bit coherency is implied.
//
// Ports:
//   clk  in  1      - destination clock
//   rst  in  1      - asynchronous active-high reset, clears every stage
//   d    in  WIDTH  - asynchronous input vector
//   q    out WIDTH  - synchronised vector, STAGES clocks behind d
module irq_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain: stage 0 is the metastability catcher, later stages
    // give it time to settle before anything downstream looks at it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/irq_req_conditioner.sv
// Interrupt request front end for the 4-line controller inc.
// Synchronises raw interrupt lines, applies per-line edge/level triggering
// and masking, and holds edge events pending until inc acknowledges them.
//
// Ports:
//   clk       in  1      - single clock, rising edge
//   rst       in  1      - asynchronous active-high reset
//   raw_irq   in  N_IRQ  - asynchronous interrupt sources
//   cfg_load  in  1      - strobe loading cfg_trig / cfg_mask, clears lost
//   cfg_trig  in  N_IRQ  - per-line trigger: 1 = rising edge, 0 = level
//   cfg_mask  in  N_IRQ  - per-line enable: 1 = enabled
//   ack       in  N_IRQ  - grant from inc.out
//   req       out N_IRQ  - conditioned requests to inc.inp
//   lost      out N_IRQ  - sticky: edge arrived while line already pending
//   irq_any   out 1      - OR of req
//
// SYNC_STAGES must be at least 2.
module irq_req_conditioner
    import inc_pkg::*;
#(
    parameter int N_IRQ       = N_IRQ_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] raw_irq,
    input  logic             cfg_load,
    input  logic [N_IRQ-1:0] cfg_trig,
    input  logic [N_IRQ-1:0] cfg_mask,
    input  logic [N_IRQ-1:0] ack,
    output logic [N_IRQ-1:0] req,
    output logic [N_IRQ-1:0] lost,
    output logic             irq_any
);

    logic [N_IRQ-1:0] trig_q;
    logic [N_IRQ-1:0] mask_q;
    logic [N_IRQ-1:0] sync;
    logic [N_IRQ-1:0] sync_d;
    logic [N_IRQ-1:0] pend_q;
    logic [N_IRQ-1:0] lost_q;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] ack_eff;
    logic [N_IRQ-1:0] pend_next;
    logic [N_IRQ-1:0] lost_next;

    irq_sync #(
        .WIDTH  (N_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_irq),
        .q   (sync)
    );

    assign rise    = sync & ~sync_d;
    // An ack only counts for a line that is actually presenting a request,
    // so a masked line keeps its stored event even if ack is stray-high.
    assign ack_eff = ack & req;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_line
        logic trig_change;

        // Switching a line's trigger mode discards whatever it had pending,
        // since the old event was captured under different semantics.
        assign trig_change = cfg_load & (cfg_trig[i] != trig_q[i]);

        // Edge lines: set beats clear so an event arriving alongside the
        // ack for the previous one is not dropped. Level lines just follow
        // the synchronised input.
        assign pend_next[i] = trig_change             ? 1'b0 :
                              (trig_q[i] == TRIG_EDGE) ? (rise[i] | (pend_q[i] & ~ack_eff[i])) :
                                                         sync[i];

        // A second edge on a still-pending line is merged, and flagged.
        assign lost_next[i] = cfg_load ? 1'b0 :
                              (lost_q[i] | ((trig_q[i] == TRIG_EDGE) & rise[i] &
                                            pend_q[i] & ~ack_eff[i]));
    end

    // Configuration registers, loaded by the cfg_load strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q <= '0;
            mask_q <= '0;
        end else if (cfg_load) begin
            trig_q <= cfg_trig;
            mask_q <= cfg_mask;
        end
    end

    // Edge-detect history plus per-line pending and lost state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_d <= '0;
            pend_q <= '0;
            lost_q <= '0;
        end else begin
            sync_d <= sync;
            pend_q <= pend_next;
            lost_q <= lost_next;
        end
    end

    assign req     = pend_q & mask_q;
    assign lost    = lost_q;
    assign irq_any = |req;

endmodule
